exp2_pipelined: RTL and testbench



---
 rtl/exp2_pipelined.sv | 125 ++++++++++++
 tb/tb_exp2_pipelined.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/exp2_pipelined.sv
// exp2_pipelined: base-2 antilog, 12-bit log code {I,F} -> DOUT = 256*2^(DIN/256), 3-stage valid/ready pipe.
// Optional macro EXP2_INTERP_EN: linear interpolation between adjacent mantissa LUT entries using F[1:0].
module exp2_pipelined (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] DIN,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [23:0] DOUT,
  output logic        out_valid,
  input  logic        out_ready
);
  localparam int unsigned INT_W   = 4;
  localparam int unsigned IDX_W   = 7;
  localparam int unsigned MANT_W  = 11;
  localparam int unsigned LUT_W   = 12;
  localparam int unsigned M4_W    = 13;
  localparam int unsigned SCALE_W = 28;
  localparam int unsigned OUT_W   = 24;

  // M[k] = round(1024 * 2^(k/64)); generated table, entry 64 (default) is 2048.
  function automatic logic [LUT_W-1:0] mant(input logic [IDX_W-1:0] idx);
    case (idx)
      7'd0:  mant = 12'd1024;  7'd1:  mant = 12'd1035;  7'd2:  mant = 12'd1046;  7'd3:  mant = 12'd1058;
      7'd4:  mant = 12'd1069;  7'd5:  mant = 12'd1081;  7'd6:  mant = 12'd1093;  7'd7:  mant = 12'd1105;
      7'd8:  mant = 12'd1117;  7'd9:  mant = 12'd1129;  7'd10: mant = 12'd1141;  7'd11: mant = 12'd1154;
      7'd12: mant = 12'd1166;  7'd13: mant = 12'd1179;  7'd14: mant = 12'd1192;  7'd15: mant = 12'd1205;
      7'd16: mant = 12'd1218;  7'd17: mant = 12'd1231;  7'd18: mant = 12'd1244;  7'd19: mant = 12'd1258;
      7'd20: mant = 12'd1272;  7'd21: mant = 12'd1286;  7'd22: mant = 12'd1300;  7'd23: mant = 12'd1314;
      7'd24: mant = 12'd1328;  7'd25: mant = 12'd1342;  7'd26: mant = 12'd1357;  7'd27: mant = 12'd1372;
      7'd28: mant = 12'd1387;  7'd29: mant = 12'd1402;  7'd30: mant = 12'd1417;  7'd31: mant = 12'd1433;
      7'd32: mant = 12'd1448;  7'd33: mant = 12'd1464;  7'd34: mant = 12'd1480;  7'd35: mant = 12'd1496;
      7'd36: mant = 12'd1512;  7'd37: mant = 12'd1529;  7'd38: mant = 12'd1545;  7'd39: mant = 12'd1562;
      7'd40: mant = 12'd1579;  7'd41: mant = 12'd1596;  7'd42: mant = 12'd1614;  7'd43: mant = 12'd1631;
      7'd44: mant = 12'd1649;  7'd45: mant = 12'd1667;  7'd46: mant = 12'd1685;  7'd47: mant = 12'd1704;
      7'd48: mant = 12'd1722;  7'd49: mant = 12'd1741;  7'd50: mant = 12'd1760;  7'd51: mant = 12'd1779;
      7'd52: mant = 12'd1798;  7'd53: mant = 12'd1818;  7'd54: mant = 12'd1838;  7'd55: mant = 12'd1858;
      7'd56: mant = 12'd1878;  7'd57: mant = 12'd1898;  7'd58: mant = 12'd1919;  7'd59: mant = 12'd1940;
      7'd60: mant = 12'd1961;  7'd61: mant = 12'd1983;  7'd62: mant = 12'd2004;  7'd63: mant = 12'd2026;
      default: mant = 12'd2048;
    endcase
  endfunction

  logic              v1, v2;
  logic              adv1, adv2, adv3;
  logic [INT_W-1:0]  i1, i2;
  logic [MANT_W-1:0] a1;
  logic [M4_W-1:0]   m4_c, m4_2;

  // Each stage moves when empty or when the stage after it moves.
  assign adv3     = !out_valid || out_ready;
  assign adv2     = !v2 || adv3;
  assign adv1     = !v1 || adv2;
  assign in_ready = adv1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1 <= 1'b0;
      i1 <= '0;
      a1 <= '0;
    end else if (adv1) begin
      v1 <= in_valid;
      if (in_valid) begin
        i1 <= DIN[11:8];
        a1 <= MANT_W'(mant({1'b0, DIN[7:2]}));
      end
    end
  end

`ifdef EXP2_INTERP_EN
  logic [LUT_W-1:0] b1;
  logic [1:0]       f21;
  logic [LUT_W-1:0] diff_c;
  logic [M4_W-1:0]  step_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b1  <= '0;
      f21 <= '0;
    end else if (adv1 && in_valid) begin
      b1  <= mant({1'b0, DIN[7:2]} + 7'd1);
      f21 <= DIN[1:0];
    end
  end

  // B >= A always, so the slope is non-negative and at most 22.
  always_comb begin
    diff_c = b1 - {1'b0, a1};
    step_c = M4_W'(diff_c) * M4_W'(f21);
    m4_c   = {a1, 2'b00} + step_c;
  end
`else
  logic unused_f2;
  assign unused_f2 = ^DIN[1:0];

  always_comb begin
    m4_c = {a1, 2'b00};
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2   <= 1'b0;
      i2   <= '0;
      m4_2 <= '0;
    end else if (adv2) begin
      v2 <= v1;
      if (v1) begin
        i2   <= i1;
        m4_2 <= m4_c;
      end
    end
  end

  // Scale by 2^I and drop the 4 extra fraction bits of M4.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      DOUT      <= '0;
    end else if (adv3) begin
      out_valid <= v2;
      if (v2) DOUT <= OUT_W'((SCALE_W'(m4_2) << i2) >> 4);
    end
  end
endmodule

// File: tb/tb_exp2_pipelined.sv
// Self-checking bench for exp2_pipelined: directed test-plan steps plus randomized traffic
// scored against a floating-point-derived reference of the antilog rules.
module tb_exp2_pipelined;
  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] din;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] dout;
  logic        out_valid;
  logic        out_ready;

  int          checks = 0;
  int          errors = 0;
  int          n_in   = 0;
  int          n_out  = 0;
  int          lut_ref[65];
  logic [23:0] exp_q[$];
  logic [23:0] cur_exp;

  exp2_pipelined dut (
    .clk       (clk),
    .rst       (rst),
    .DIN       (din),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .DOUT      (dout),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference: mantissa from 2^(k/64) in real arithmetic, then the scale/interp rules.
  function automatic logic [23:0] ref_exp(input logic [11:0] d);
    int i, k, m4;
    i = int'(d[11:8]);
    k = int'(d[7:2]);
`ifdef EXP2_INTERP_EN
    m4 = 4 * lut_ref[k] + (lut_ref[k+1] - lut_ref[k]) * int'(d[1:0]);
`else
    m4 = 4 * lut_ref[k];
`endif
    return 24'((m4 << i) >> 4);
  endfunction

  // One clock: score any transfers seen just before the edge, then advance to the next negedge.
  task automatic clk_step();
    #1;
    if (out_valid && out_ready) begin
      n_out++;
      check("out_unexpected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("dout", 32'(dout), 32'(exp_q.pop_front()));
    end
    if (in_valid && in_ready) begin
      n_in++;
      exp_q.push_back(cur_exp);
    end
    @(negedge clk);
  endtask

  task automatic drain(input int budget);
    int b = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && b < budget) begin
      clk_step();
      b++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic send(input logic [11:0] d, input logic [23:0] e);
    din = d; cur_exp = e; in_valid = 1'b1; out_ready = 1'b1;
    clk_step();
    in_valid = 1'b0;
    drain(20);
  endtask

  initial begin
    int base_in, base_out;
    logic [23:0] held;

    for (int k = 0; k <= 64; k++) lut_ref[k] = $rtoi(1024.0 * $pow(2.0, real'(k) / 64.0) + 0.5);

    rst = 1'b1; din = '0; in_valid = 1'b0; out_ready = 1'b0; cur_exp = '0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);

    // Latency: DIN=0 appears exactly 3 cycles after the transfer.
    din = 12'h000; cur_exp = 24'h000100; in_valid = 1'b1; out_ready = 1'b1;
    clk_step();
    in_valid = 1'b0;
    check("lat_c1_valid", 32'(out_valid), 32'd0);
    check("lat_c1_dout", 32'(dout), 32'd0);
    clk_step();
    check("lat_c2_valid", 32'(out_valid), 32'd0);
    check("lat_c2_dout", 32'(dout), 32'd0);
    clk_step();
    check("lat_c3_valid", 32'(out_valid), 32'd1);
    check("lat_c3_dout", 32'(dout), 32'h000100);
    drain(10);

    send(12'h100, 24'h000200);
    send(12'hF00, 24'h800000);
    send(12'h080, 24'h00016A);
`ifdef EXP2_INTERP_EN
    send(12'hFFF, 24'hFF5000);
`else
    send(12'hFFF, 24'hFD4000);
`endif

    // Back-to-back powers of two: 16 results on consecutive cycles.
    base_out = n_out;
    out_ready = 1'b1;
    for (int j = 0; j < 16; j++) begin
      din = 12'(j << 8); cur_exp = 24'(32'h100 << j); in_valid = 1'b1;
      #1;
      check("stream_in_ready", 32'(in_ready), 32'd1);
      clk_step();
    end
    in_valid = 1'b0;
    for (int j = 0; j < 3; j++) clk_step();
    check("stream_outputs", 32'(n_out - base_out), 32'd16);
    check("stream_left", 32'(exp_q.size()), 32'd0);

    // Output stall for 6 cycles from empty: exactly 3 accepts, then hold.
    base_in = n_in; base_out = n_out; held = '0;
    out_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      din = 12'($urandom); cur_exp = ref_exp(din); in_valid = 1'b1;
      clk_step();
      if (c == 3) held = dout;
    end
    check("stall_accepts", 32'(n_in - base_in), 32'd3);
    check("stall_in_ready", 32'(in_ready), 32'd0);
    check("stall_out_valid", 32'(out_valid), 32'd1);
    check("stall_dout_held", 32'(dout), 32'(held));
    check("stall_dout_head", 32'(dout), 32'(exp_q[0]));
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      din = 12'($urandom); cur_exp = ref_exp(din); in_valid = 1'b1;
      clk_step();
    end
    drain(20);
    check("stall_no_loss_dup", 32'(n_out - base_out), 32'(n_in - base_in));

    // Reset with three items in flight.
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      din = 12'($urandom); cur_exp = ref_exp(din); in_valid = 1'b1;
      clk_step();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_dout", 32'(dout), 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    din = 12'($urandom); cur_exp = ref_exp(din); in_valid = 1'b1;
    clk_step();
    in_valid = 1'b0;
    check("post_rst_c1", 32'(out_valid), 32'd0);
    clk_step();
    check("post_rst_c2", 32'(out_valid), 32'd0);
    clk_step();
    check("post_rst_c3_valid", 32'(out_valid), 32'd1);
    check("post_rst_c3_dout", 32'(dout), 32'(cur_exp));
    drain(10);

    // Random traffic with random backpressure; DIN changes even when not accepted.
    base_in = n_in; base_out = n_out;
    for (int c = 0; c < 400; c++) begin
      din       = 12'($urandom);
      cur_exp   = ref_exp(din);
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      clk_step();
    end
    drain(50);
    check("rand_no_loss_dup", 32'(n_out - base_out), 32'(n_in - base_in));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
